// File: rtl/mult_seq_ctrl_if.sv
// Control bundle between the multiplier handshake/datapath and the one-hot sequencer.
interface mult_seq_ctrl_if #(
   parameter int CW = 3
);
   logic          START;
   logic          ABORT;
   logic          LSB;
   logic          LOAD;
   logic          ADD;
   logic          SHIFT;
   logic          BUSY;
   logic          DONE;
   logic [CW-1:0] COUNT;

   modport master (
      output START, ABORT, LSB,
      input  LOAD, ADD, SHIFT, BUSY, DONE, COUNT
   );

   modport slave (
      input  START, ABORT, LSB,
      output LOAD, ADD, SHIFT, BUSY, DONE, COUNT
   );
endinterface

// File: rtl/mult_seq_ctrl.sv
// One-hot sequencer for a shift-and-add multiplier: LOAD, then per bit TEST/[ADD]/SHIFT, then DONE.
module mult_seq_ctrl #(
   parameter int WIDTH = 4,
   parameter int CW    = 3
) (
   input  logic            CLK,
   input  logic            RESET,
   mult_seq_ctrl_if.slave  bus
);

   typedef enum logic [5:0] {
      IDLE = 6'b000001,
      LD   = 6'b000010,
      TEST = 6'b000100,
      ADDS = 6'b001000,
      SHF  = 6'b010000,
      FIN  = 6'b100000
   } state_t;

   localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

   // Plain vector so a corrupted (non one-hot) value is representable and recoverable.
   logic [5:0]    state_reg;
   state_t        state_next;
   logic          busy_reg;
   logic [CW-1:0] count_reg;
   logic [CW-1:0] count_next;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_reg <= IDLE;
         busy_reg  <= 1'b0;
         count_reg <= '0;
      end else begin
         state_reg <= state_next;
         busy_reg  <= (state_next != IDLE);
         count_reg <= count_next;
      end
   end

   always_comb begin
      state_next = IDLE;
      count_next = count_reg;
      case (state_reg)
         IDLE: state_next = bus.START ? LD : IDLE;
         LD: begin
            if (!bus.ABORT) begin
               count_next = '0;
               state_next = TEST;
            end
         end
         TEST: begin
            if (!bus.ABORT)
               state_next = bus.LSB ? ADDS : SHF;
         end
         ADDS: begin
            if (!bus.ABORT)
               state_next = SHF;
         end
         SHF: begin
            // The shift strobe has already been issued, so the iteration counts even if aborted.
            count_next = count_reg + CW'(1);
            if (!bus.ABORT)
               state_next = (count_reg == LAST_ITER) ? FIN : TEST;
         end
         FIN:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign bus.LOAD  = state_reg[1];
   assign bus.ADD   = state_reg[3];
   assign bus.SHIFT = state_reg[4];
   assign bus.DONE  = state_reg[5];
   assign bus.BUSY  = busy_reg;
   assign bus.COUNT = count_reg;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Cycle-by-cycle scoreboard bench: each queued record carries the inputs for that cycle and the expected outputs.
module tb_mult_seq_ctrl;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   mult_seq_ctrl_if #(.CW(3)) bus ();

   mult_seq_ctrl #(.WIDTH(4), .CW(3)) dut (
      .CLK   (clk),
      .RESET (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      tag;
      logic       ld;
      logic       ad;
      logic       sh;
      logic       bu;
      logic       dn;
      logic [2:0] cnt;
      logic       st;
      logic       ab;
      logic       rs;
      logic       lsb;
   } rec_t;

   rec_t q[$];

   task automatic p(input string tag, input logic ld, input logic ad, input logic sh,
                    input logic bu, input logic dn, input logic [2:0] cnt,
                    input logic st, input logic ab, input logic rs, input logic lsb);
      rec_t r;
      r.tag = tag; r.ld = ld; r.ad = ad; r.sh = sh; r.bu = bu; r.dn = dn; r.cnt = cnt;
      r.st = st; r.ab = ab; r.rs = rs; r.lsb = lsb;
      q.push_back(r);
   endtask

   task automatic idle(input string nm, input int n, input logic [2:0] cnt, input logic st_last);
      for (int i = 0; i < n; i++)
         p($sformatf("%s_idle%0d", nm, i), 0, 0, 0, 0, 0, cnt, (i == n - 1) ? st_last : 1'b0, 0, 0, 0);
   endtask

   // Expected timeline from the latency rules: LD, then per bit TEST, ADD if bit set, SHIFT; then DONE.
   task automatic run(input string nm, input logic [3:0] m, input logic [2:0] prev,
                      input int abort_at, input logic hold);
      p({nm, "_ld"}, 1, 0, 0, 1, 0, prev, hold, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         p($sformatf("%s_test%0d", nm, i), 0, 0, 0, 1, 0, 3'(i), hold, 0, 0, m[i]);
         if (m[i])
            p($sformatf("%s_add%0d", nm, i), 0, 1, 0, 1, 0, 3'(i), hold, 0, 0, 0);
         p($sformatf("%s_shf%0d", nm, i), 0, 0, 1, 1, 0, 3'(i), hold, (abort_at == i), 0, 0);
         if (abort_at == i) return;
      end
      p({nm, "_done"}, 0, 0, 0, 1, 1, 3'd4, hold, 0, 0, 0);
   endtask

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic check_outputs(input rec_t r);
      chk({r.tag, ".LOAD"},  8'(bus.LOAD),  8'(r.ld));
      chk({r.tag, ".ADD"},   8'(bus.ADD),   8'(r.ad));
      chk({r.tag, ".SHIFT"}, 8'(bus.SHIFT), 8'(r.sh));
      chk({r.tag, ".BUSY"},  8'(bus.BUSY),  8'(r.bu));
      chk({r.tag, ".DONE"},  8'(bus.DONE),  8'(r.dn));
      chk({r.tag, ".COUNT"}, 8'(bus.COUNT), 8'(r.cnt));
      $display("cycle %-12s LOAD=%b ADD=%b SHIFT=%b BUSY=%b DONE=%b COUNT=%0d", r.tag,
               bus.LOAD, bus.ADD, bus.SHIFT, bus.BUSY, bus.DONE, bus.COUNT);
   endtask

   task automatic drain();
      rec_t r;
      while (q.size() > 0) begin
         r = q.pop_front();
         @(negedge clk);
         check_outputs(r);
         bus.START = r.st;
         bus.ABORT = r.ab;
         bus.LSB   = r.lsb;
         rst       = r.rs;
      end
   endtask

   initial begin
      rec_t r;
      checks    = 0;
      errors    = 0;
      rst       = 1'b1;
      bus.START = 1'b0;
      bus.ABORT = 1'b0;
      bus.LSB   = 1'b0;
      repeat (2) @(posedge clk);

      p("reset", 0, 0, 0, 0, 0, 3'd0, 0, 0, 1, 0);
      idle("pre", 2, 3'd0, 1'b1);
      run("m1011", 4'b1011, 3'd0, -1, 1'b0);
      idle("m1011", 1, 3'd4, 1'b1);
      run("m0000", 4'b0000, 3'd4, -1, 1'b0);
      idle("m0000", 2, 3'd4, 1'b1);
      run("abort", 4'b0101, 3'd4, 1, 1'b0);
      idle("abort", 2, 3'd2, 1'b1);
      run("fresh", 4'b0110, 3'd2, -1, 1'b0);
      idle("hold", 1, 3'd4, 1'b1);
      run("hold1", 4'b1001, 3'd4, -1, 1'b1);
      idle("hold_gap", 1, 3'd4, 1'b1);
      run("hold2", 4'b0011, 3'd4, -1, 1'b0);
      idle("post", 1, 3'd4, 1'b1);
      // Reset asserted for two cycles while in the second TEST.
      p("rst_ld",    1, 0, 0, 1, 0, 3'd4, 0, 0, 0, 0);
      p("rst_test0", 0, 0, 0, 1, 0, 3'd0, 0, 0, 0, 0);
      p("rst_shf0",  0, 0, 1, 1, 0, 3'd0, 0, 0, 0, 0);
      p("rst_test1", 0, 0, 0, 1, 0, 3'd1, 1, 1, 1, 1);
      p("rst_idle0", 0, 0, 0, 0, 0, 3'd0, 1, 0, 1, 0);
      p("rst_idle1", 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0);
      // Reset, abort and start together in IDLE.
      p("all_hi",    0, 0, 0, 0, 0, 3'd0, 1, 1, 1, 1);
      p("all_after", 0, 0, 0, 0, 0, 3'd0, 1, 0, 0, 0);
      p("frc_ld",    1, 0, 0, 1, 0, 3'd0, 0, 0, 0, 0);
      p("frc_test",  0, 0, 0, 1, 0, 3'd0, 0, 0, 0, 1);
      drain();

      // Corrupt the state vector mid-TEST; the next edge must recover to IDLE.
      force dut.state_reg = 6'b000000;
      #1;
      release dut.state_reg;
      r.tag = "forced_zero"; r.ld = 0; r.ad = 0; r.sh = 0; r.bu = 0; r.dn = 0; r.cnt = 3'd0;
      @(negedge clk);
      check_outputs(r);
      r.tag = "forced_hold";
      @(negedge clk);
      check_outputs(r);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
